// File: rtl/prng_pkg.sv
// Shared types for the PRNG request interface: requester FSM states,
// command select encodings and the 8-bit sample word.
package prng_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEED,
        ST_GAP,
        ST_REQ,
        ST_WAIT,
        ST_FIN
    } prng_req_state_t;

    localparam logic PRNG_SEL_SEED = 1'b0;
    localparam logic PRNG_SEL_NEXT = 1'b1;

    typedef logic [7:0] prng_word_t;

endpackage

// File: rtl/prng_sample_fifo.sv
// Small show-ahead FIFO for returned PRNG samples; head is read straight
// out of the storage array so a pop needs no extra cycle.
module prng_sample_fifo
    import prng_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  prng_word_t                   push_data,
    input  logic                         pop,
    output prng_word_t                   head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    prng_word_t     mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A simultaneous pop frees the slot, so push into a full FIFO is fine then.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/prng_requester.sv
// Initiator for the 8-bit PRNG: seeds it, paces request pulses, and buffers
// each returned number in a sample FIFO for the downstream consumer.
module prng_requester
    import prng_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255,
    parameter int GAP_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       seed_in,
    input  logic [7:0]       count_in,
    input  logic [GAP_W-1:0] gap_in,
    output logic             prng_en,
    output logic             prng_sel,
    output logic [7:0]       prng_seed,
    input  logic             prng_valid,
    input  logic [7:0]       prng_num,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             timeout_err
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    prng_req_state_t  state, state_next;
    prng_word_t       seed_r;
    logic [7:0]       remain_r;
    logic [GAP_W-1:0] gap_r;
    logic [GAP_W-1:0] gap_cnt;
    logic [TW-1:0]    tmo_cnt;
    logic             fifo_push;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_cnt_unused;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_SEED;
            ST_SEED: state_next = (remain_r == 8'd0) ? ST_FIN : ST_GAP;
            // Never issue a request unless its answer is guaranteed a slot.
            ST_GAP:  if (gap_cnt == '0 && !fifo_full) state_next = ST_REQ;
            ST_REQ:  state_next = ST_WAIT;
            ST_WAIT: begin
                if (prng_valid)              state_next = (remain_r == 8'd1) ? ST_FIN : ST_GAP;
                else if (tmo_cnt == TMO_LAST) state_next = ST_FIN;
            end
            ST_FIN:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        prng_en   = 1'b0;
        prng_sel  = PRNG_SEL_SEED;
        prng_seed = '0;
        case (state)
            ST_SEED: begin
                prng_en   = 1'b1;
                prng_seed = seed_r;
            end
            ST_REQ: begin
                prng_en  = 1'b1;
                prng_sel = PRNG_SEL_NEXT;
            end
            default: ;
        endcase
        busy = (state != ST_IDLE);
        done = (state == ST_FIN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seed_r      <= '0;
            remain_r    <= '0;
            gap_r       <= '0;
            gap_cnt     <= '0;
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    seed_r      <= seed_in;
                    remain_r    <= count_in;
                    gap_r       <= gap_in;
                    timeout_err <= 1'b0;
                end
                ST_SEED: gap_cnt <= gap_r;
                ST_GAP:  if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
                ST_REQ:  tmo_cnt <= '0;
                ST_WAIT: begin
                    // A result arriving on the final timeout cycle still counts.
                    if (prng_valid) begin
                        remain_r <= remain_r - 8'd1;
                        gap_cnt  <= gap_r;
                    end else if (tmo_cnt == TMO_LAST) begin
                        timeout_err <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign fifo_push = (state == ST_WAIT) && prng_valid;
    assign out_valid = !fifo_empty;

    prng_sample_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (prng_num),
        .pop       (out_ready),
        .head      (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_cnt_unused)
    );

endmodule

// File: tb/tb_prng_requester.sv
// Bench for prng_requester: a PRNG responder model feeds random numbers,
// a scoreboard queue holds what the FIFO should deliver, in order.
module tb_prng_requester;

    localparam int DEPTH = 4, TIMEOUT = 255, GAP_W = 8;

    logic clk = 1'b0;
    logic reset = 1'b1, start = 1'b0, out_ready = 1'b0;
    logic [7:0] seed_in = '0, count_in = '0;
    logic [GAP_W-1:0] gap_in = '0;
    logic prng_valid = 1'b0;
    logic [7:0] prng_num = '0;
    logic prng_en, prng_sel, out_valid, busy, done, timeout_err;
    logic [7:0] prng_seed, out_data;

    int vectors = 0, errors = 0;
    int cyc = 0, pend = -1, resp_dly = 2;
    bit resp_on = 1'b1, stray_req = 1'b0, prev_en = 1'b0;
    int seed_pulses, req_pulses, done_pulses, pops, min_space;
    int last_req_cyc, last_seed_cyc, last_done_cyc;
    logic [7:0] seed_seen, exp_v;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    prng_requester #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .GAP_W(GAP_W)) dut (
        .clk(clk), .reset(reset), .start(start), .seed_in(seed_in),
        .count_in(count_in), .gap_in(gap_in), .prng_en(prng_en),
        .prng_sel(prng_sel), .prng_seed(prng_seed), .prng_valid(prng_valid),
        .prng_num(prng_num), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done), .timeout_err(timeout_err)
    );

    // Monitor + PRNG model, all at negedge (away from the active edge).
    always @(negedge clk) begin
        bit new_req;
        new_req = 1'b0;
        cyc++;
        if (reset) begin
            pend = -1; prng_valid = 1'b0; exp_q.delete(); prev_en = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                pops++; vectors++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL pop_unexpected: got %h, model queue empty", out_data);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (out_data !== exp_v) begin
                        errors++; $display("FAIL pop_data: got %h expected %h", out_data, exp_v);
                    end
                end
            end
            if (prng_en) begin
                vectors++;
                if (prev_en) begin
                    errors++; $display("FAIL en_back_to_back: prng_en high 2 cycles at cyc %0d", cyc);
                end
                if (prng_sel == 1'b0) begin
                    seed_pulses++; seed_seen = prng_seed; last_seed_cyc = cyc;
                end else begin
                    if (last_req_cyc >= 0 && cyc - last_req_cyc < min_space) min_space = cyc - last_req_cyc;
                    last_req_cyc = cyc; req_pulses++; new_req = 1'b1;
                end
            end
            prev_en = prng_en;
            if (done) begin done_pulses++; last_done_cyc = cyc; end
            prng_valid = 1'b0;
            if (stray_req) begin
                prng_valid = 1'b1; prng_num = 8'hA5; stray_req = 1'b0;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    prng_valid = 1'b1; prng_num = 8'($urandom);
                    exp_q.push_back(prng_num); pend = -1;
                end
            end
            if (new_req && resp_on) pend = resp_dly;
        end
    end

    task automatic clear_stats();
        seed_pulses = 0; req_pulses = 0; done_pulses = 0; pops = 0;
        min_space = 1000000; last_req_cyc = -1; last_seed_cyc = -1; last_done_cyc = -1;
    endtask

    task automatic do_start(input logic [7:0] s, input logic [7:0] c, input logic [GAP_W-1:0] g);
        @(posedge clk); #1;
        seed_in = s; count_in = c; gap_in = g; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, input bit rand_ready, input string name);
        int n = 0;
        while (done_pulses == 0 && n < bound) begin
            @(posedge clk); #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            n++;
        end
        vectors++;
        if (done_pulses == 0) begin
            errors++; $display("FAIL %s_done_wait: no done within %0d cycles", name, bound);
        end
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        for (int i = 0; i < 20 && out_valid; i++) begin @(posedge clk); #1; end
        vectors++;
        if (out_valid !== 1'b0 || exp_q.size() != 0) begin
            errors++; $display("FAIL %s_drain: out_valid=%b model left=%0d required 0/0", name, out_valid, exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({prng_en, prng_sel, prng_seed, out_valid, out_data, busy, done, timeout_err} !== '0) begin
            errors++;
            $display("FAIL reset_state: en=%b sel=%b seed=%h ov=%b od=%h busy=%b done=%b err=%b required all 0",
                     prng_en, prng_sel, prng_seed, out_valid, out_data, busy, done, timeout_err);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_run();
        clear_stats(); out_ready = 1'b1; resp_dly = 2; resp_on = 1'b1;
        do_start(8'hCC, 8'd3, 8'd4);
        wait_done(300, 1'b0, "basic");
        drain("basic");
        vectors++;
        if (seed_pulses != 1 || seed_seen !== 8'hCC) begin
            errors++; $display("FAIL basic_seed: pulses=%0d seed=%h required 1/cc", seed_pulses, seed_seen);
        end
        vectors++;
        if (req_pulses != 3 || pops != 3 || done_pulses != 1) begin
            errors++; $display("FAIL basic_counts: req=%0d pops=%0d done=%0d required 3/3/1", req_pulses, pops, done_pulses);
        end
        // REQ, 2 WAIT cycles, gap+1 GAP cycles, then next REQ
        vectors++;
        if (min_space != 8) begin
            errors++; $display("FAIL basic_spacing: req spacing %0d required 8", min_space);
        end
        vectors++;
        if (timeout_err !== 1'b0) begin
            errors++; $display("FAIL basic_err: timeout_err=%b required 0", timeout_err);
        end
    endtask

    task automatic test_count_zero();
        clear_stats(); out_ready = 1'b1;
        do_start(8'h11, 8'd0, 8'd3);
        wait_done(20, 1'b0, "zero");
        vectors++;
        if (seed_pulses != 1 || req_pulses != 0 || last_done_cyc - last_seed_cyc != 1) begin
            errors++; $display("FAIL zero_run: seed=%0d req=%0d done-seed=%0d required 1/0/1",
                               seed_pulses, req_pulses, last_done_cyc - last_seed_cyc);
        end
    endtask

    task automatic test_backpressure();
        clear_stats(); out_ready = 1'b0; resp_dly = 1;
        do_start(8'h3C, 8'd6, 8'd1);
        repeat (80) begin @(posedge clk); #1; end
        vectors++;
        if (req_pulses != DEPTH || busy !== 1'b1 || pops != 0 || out_valid !== 1'b1) begin
            errors++; $display("FAIL full_stall: req=%0d busy=%b pops=%0d ov=%b required %0d/1/0/1",
                               req_pulses, busy, pops, out_valid, DEPTH);
        end
        out_ready = 1'b1;
        wait_done(200, 1'b0, "full");
        drain("full");
        vectors++;
        if (req_pulses != 6 || pops != 6) begin
            errors++; $display("FAIL full_resume: req=%0d pops=%0d required 6/6", req_pulses, pops);
        end
    endtask

    task automatic test_timeout();
        clear_stats(); out_ready = 1'b1; resp_on = 1'b0;
        do_start(8'h77, 8'd2, 8'd0);
        wait_done(400, 1'b0, "tmo");
        vectors++;
        if (timeout_err !== 1'b1 || req_pulses != 1 || last_done_cyc - last_req_cyc != 256) begin
            errors++; $display("FAIL tmo_run: err=%b req=%0d done-req=%0d required 1/1/256",
                               timeout_err, req_pulses, last_done_cyc - last_req_cyc);
        end
        resp_on = 1'b1; resp_dly = 3; clear_stats();
        do_start(8'h78, 8'd1, 8'd0);
        vectors++;
        if (timeout_err !== 1'b0) begin
            errors++; $display("FAIL tmo_clear: timeout_err=%b after start required 0", timeout_err);
        end
        wait_done(100, 1'b0, "tmo_rerun");
        drain("tmo_rerun");
    endtask

    task automatic test_ignored_inputs();
        clear_stats(); out_ready = 1'b1; resp_dly = 3;
        do_start(8'h5A, 8'd3, 8'd20);
        @(posedge clk); #1;
        stray_req = 1'b1;
        @(posedge clk); #1;
        count_in = 8'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(300, 1'b0, "ignore");
        drain("ignore");
        repeat (5) begin @(posedge clk); #1; end
        vectors++;
        if (req_pulses != 3 || pops != 3 || done_pulses != 1 || busy !== 1'b0) begin
            errors++; $display("FAIL ignore_counts: req=%0d pops=%0d done=%0d busy=%b required 3/3/1/0",
                               req_pulses, pops, done_pulses, busy);
        end
    endtask

    task automatic test_reset_mid_run();
        int n = 0;
        clear_stats(); out_ready = 1'b0; resp_dly = 4;
        do_start(8'h42, 8'd5, 8'd2);
        while (req_pulses < 3 && n < 200) begin @(posedge clk); #1; n++; end
        vectors++;
        if (req_pulses != 3 || out_valid !== 1'b1) begin
            errors++; $display("FAIL midrst_setup: req=%0d ov=%b required 3/1", req_pulses, out_valid);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || prng_en !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL midrst_state: busy=%b ov=%b en=%b done=%b required 0/0/0/0",
                               busy, out_valid, prng_en, done);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (prng_en !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL midrst_after: en=%b busy=%b required 0/0", prng_en, busy);
        end
    endtask

    task automatic test_random_runs();
        for (int r = 0; r < 5; r++) begin
            logic [7:0] s, c;
            logic [GAP_W-1:0] g;
            s = 8'($urandom); c = 8'($urandom_range(1, 9)); g = GAP_W'($urandom_range(0, 6));
            resp_dly = $urandom_range(1, 5);
            clear_stats();
            do_start(s, c, g);
            wait_done(3000, 1'b1, "rand");
            drain("rand");
            vectors++;
            if (seed_seen !== s || req_pulses != int'(c) || pops != int'(c) || timeout_err !== 1'b0) begin
                errors++; $display("FAIL rand_run%0d: seed=%h/%h req=%0d pops=%0d count=%0d err=%b",
                                   r, seed_seen, s, req_pulses, pops, c, timeout_err);
            end
            vectors++;
            if (c > 1 && min_space < resp_dly + int'(g) + 2) begin
                errors++; $display("FAIL rand_spacing%0d: spacing %0d required >= %0d",
                                   r, min_space, resp_dly + int'(g) + 2);
            end
        end
    endtask

    initial begin
        clear_stats();
        test_reset();
        test_basic_run();
        test_count_zero();
        test_backpressure();
        test_timeout();
        test_ignored_inputs();
        test_reset_mid_run();
        test_random_runs();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
